crc_frame_sequencer: RTL

Sequences the serial CRC LFSR datapath: accepts a parallel message word over a valid/ready handshake and feeds it MSB-first, one bit per cycle, into a serial CRC engine. It streams the message bits out serially and optionally appends the CRC remainder as a trailer. It then presents the final remainder with a one-cycle done pulse. It sits between the parallel word source and the serial link or CRC consumer, and owns clearing, enabling and freezing the LFSR.

---
 rtl/crc_pkg.sv | 16 +
 rtl/crc_serial_lfsr.sv | 30 +++
 rtl/crc_frame_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// crc_pkg: shared FSM encoding and default parameters for the serial CRC frame sequencer.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int         DEF_MSG_W = 6;
    localparam int         DEF_CRC_W = 5;
    localparam logic [4:0] DEF_POLY  = 5'h05;
    localparam logic [4:0] DEF_INIT  = 5'h00;

endpackage

// File: rtl/crc_serial_lfsr.sv
// crc_serial_lfsr: bit-serial CRC LFSR, MSB-out feedback; clr loads init, en advances one bit.
module crc_serial_lfsr
    import crc_pkg::*;
#(
    parameter int               CRC_W = DEF_CRC_W,
    parameter logic [CRC_W-1:0] POLY  = DEF_POLY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [CRC_W-1:0] init,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic fb;

    assign fb = crc[CRC_W-1] ^ bit_in;

    always_ff @(posedge clk) begin
        if (reset)
            crc <= '0;
        else if (clr)
            crc <= init;
        else if (en)
            crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

endmodule

// File: rtl/crc_frame_sequencer.sv
// crc_frame_sequencer: streams a parallel word MSB-first through a serial CRC LFSR.
// Define CRC_SERIAL_APPEND_EN to append the CRC remainder as a serial trailer.
module crc_frame_sequencer
    import crc_pkg::*;
#(
    parameter int               MSG_W = DEF_MSG_W,
    parameter int               CRC_W = DEF_CRC_W,
    parameter logic [CRC_W-1:0] POLY  = DEF_POLY,
    parameter logic [CRC_W-1:0] INIT  = DEF_INIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MSG_W-1:0] in_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_out,
    output logic             ser_last,
    output logic [CRC_W-1:0] crc_out,
    output logic             done
);

    localparam int CNT_W = $clog2(MSG_W > CRC_W ? MSG_W : CRC_W);

    state_t             state, state_nx;
    logic [MSG_W-1:0]   msg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CRC_W-1:0]   lfsr;
    logic               accept, beat, last_bit;

    assign accept   = in_valid & in_ready;
    assign beat     = ser_valid & ser_ready;
    assign last_bit = bit_cnt == '0;

    crc_serial_lfsr #(.CRC_W(CRC_W), .POLY(POLY)) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .init   (INIT),
        .en     (beat && state == SHIFT),
        .bit_in (ser_out),
        .crc    (lfsr)
    );

`ifdef CRC_SERIAL_APPEND_EN
    logic [CRC_W-1:0] trailer, cur;

    // The frozen LFSR seeds the first trailer bit; later bits come from the shifted copy.
    assign cur = (bit_cnt == CNT_W'(CRC_W-1)) ? lfsr : trailer;

    always_ff @(posedge clk) begin
        if (reset)
            trailer <= '0;
        else if (beat && state == EMIT)
            trailer <= {cur[CRC_W-2:0], 1'b0};
    end
`endif

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        ser_last  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = SHIFT;
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = msg[bit_cnt];
`ifdef CRC_SERIAL_APPEND_EN
                if (beat && last_bit) state_nx = EMIT;
`else
                ser_last  = last_bit;
                if (beat && last_bit) state_nx = DONE;
`endif
            end
`ifdef CRC_SERIAL_APPEND_EN
            EMIT: begin
                ser_valid = 1'b1;
                ser_out   = cur[CRC_W-1];
                ser_last  = last_bit;
                if (beat && last_bit) state_nx = DONE;
            end
`endif
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            msg     <= '0;
            bit_cnt <= '0;
            crc_out <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                msg     <= in_data;
                bit_cnt <= CNT_W'(MSG_W-1);
            end else if (beat) begin
                bit_cnt <= last_bit ? CNT_W'(CRC_W-1) : bit_cnt - 1'b1;
            end
            if (done) crc_out <= lfsr;
        end
    end

endmodule
